// File: rtl/bus_slave_memory.sv
`default_nettype none
// ============================================================================
// Module      : bus_slave_memory
// Description : 512 x 32-bit byte-writable bus slave RAM with burst reads and
//               writes, bus-error reporting and optional periodic write busy.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_slave_memory #(
    parameter logic [31:0] baseAddress = 32'h5000_0000,
    parameter int unsigned busyPeriod  = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        beginTransactionIn,
    input  logic [31:0] addressDataIn,
    input  logic [3:0]  byteEnablesIn,
    input  logic [7:0]  burstSizeIn,
    input  logic        readNotWriteIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    output logic [31:0] addressDataOut,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    output logic        busErrorOut,
    output logic        busyOut
);

    localparam int unsigned c_WORDS     = 512;
    localparam logic [31:0] c_BUSY_LAST = 32'(busyPeriod - 1);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] READ_WAIT   = 3'd1;
    localparam logic [2:0] READ_BURST  = 3'd2;
    localparam logic [2:0] READ_END    = 3'd3;
    localparam logic [2:0] WRITE       = 3'd4;
    localparam logic [2:0] WRITE_DRAIN = 3'd5;
    localparam logic [2:0] ERROR_END   = 3'd6;

    logic [2:0]  r_state;
    logic [8:0]  r_word;
    logic [8:0]  r_beats_left;
    logic [3:0]  r_be;
    logic        r_read;
    logic        r_busy;
    logic [31:0] r_busy_cnt;
    logic [31:0] r_mem [c_WORDS];
    logic [31:0] r_rdata;

    logic        w_select;
    logic [8:0]  w_req_beats;
    logic [9:0]  w_span;
    logic        w_error;
    logic        w_accept;
    logic        w_we;
    logic        w_re;

    assign w_select    = beginTransactionIn && (addressDataIn[31:11] == baseAddress[31:11]);
    assign w_req_beats = {1'b0, burstSizeIn} + 9'd1;
    assign w_span      = {1'b0, addressDataIn[10:2]} + {1'b0, w_req_beats};
    assign w_error     = (addressDataIn[1:0] != 2'b00) || (w_span > 10'd512);
    assign w_accept    = (r_state == WRITE) && dataValidIn && !r_busy;
    assign w_we        = w_accept && (r_beats_left != 9'd0);
    // The last read beat needs no prefetch, so the word pointer never reads past the burst.
    assign w_re        = (r_state == READ_WAIT) || ((r_state == READ_BURST) && (r_beats_left > 9'd1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_beats_left <= '0;
            r_be         <= '0;
            r_read       <= 1'b0;
            r_busy       <= 1'b0;
            r_busy_cnt   <= '0;
        end else begin
            r_busy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_select) begin
                        r_word       <= addressDataIn[10:2];
                        r_beats_left <= w_req_beats;
                        r_be         <= byteEnablesIn;
                        r_read       <= readNotWriteIn;
                        r_busy_cnt   <= '0;
                        if (w_error)
                            r_state <= ERROR_END;
                        else if (readNotWriteIn)
                            r_state <= READ_WAIT;
                        else
                            r_state <= WRITE;
                    end
                end
                READ_WAIT: begin
                    if (endTransactionIn) begin
                        r_state <= IDLE;
                    end else begin
                        r_word  <= r_word + 9'd1;
                        r_state <= READ_BURST;
                    end
                end
                READ_BURST: begin
                    if (endTransactionIn) begin
                        r_state <= IDLE;
                    end else begin
                        r_word       <= r_word + 9'd1;
                        r_beats_left <= r_beats_left - 9'd1;
                        if (r_beats_left == 9'd1)
                            r_state <= READ_END;
                    end
                end
                READ_END: begin
                    r_state <= IDLE;
                end
                WRITE: begin
                    if (w_accept) begin
                        if (w_we) begin
                            r_word       <= r_word + 9'd1;
                            r_beats_left <= r_beats_left - 9'd1;
                        end
                        if (busyPeriod != 0) begin
                            if (r_busy_cnt == c_BUSY_LAST) begin
                                r_busy_cnt <= '0;
                                r_busy     <= !endTransactionIn;
                            end else begin
                                r_busy_cnt <= r_busy_cnt + 32'd1;
                            end
                        end
                    end
                    if (endTransactionIn)
                        r_state <= IDLE;
                end
                WRITE_DRAIN: begin
                    if (endTransactionIn)
                        r_state <= IDLE;
                end
                ERROR_END: begin
                    // A failed write still has to be drained until the master ends it.
                    if (r_read || endTransactionIn)
                        r_state <= IDLE;
                    else
                        r_state <= WRITE_DRAIN;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i])
                    r_mem[r_word][8*i +: 8] <= addressDataIn[8*i +: 8];
            end
        end else if (w_re) begin
            r_rdata <= r_mem[r_word];
        end
    end

    // Outputs decode from state only, so reset clears them without waiting for a clock.
    assign dataValidOut      = (r_state == READ_BURST);
    assign addressDataOut    = dataValidOut ? r_rdata : 32'd0;
    assign endTransactionOut = (r_state == READ_END) || ((r_state == ERROR_END) && r_read);
    assign busErrorOut       = (r_state == ERROR_END);
    assign busyOut           = r_busy && (r_state == WRITE);

endmodule
`default_nettype wire
